// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the three-way Wishbone memory arbiter.
package wb_arb_pkg;

    localparam int NUM_M = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_t;

    // Bits needed for a WAIT-cycle counter that must reach the value t.
    function automatic int cnt_width(input int t);
        return $clog2(t + 1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: searches from last+1 (mod 3) for the
// first active request and returns it one-hot.
module rr_pick
    import wb_arb_pkg::*;
(
    input  logic [2:0] i_req,
    input  logic [1:0] i_last,
    output logic [2:0] o_grant,
    output logic       o_valid
);

    int w_idx;

    // Walk the three candidates in rotated order; first requester wins.
    always_comb begin
        o_grant = '0;
        o_valid = 1'b0;
        w_idx   = 0;
        for (int k = 1; k <= NUM_M; k++) begin
            w_idx = (int'(i_last) + k) % NUM_M;
            if (!o_valid && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                o_valid        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_mem_arbiter.sv
// Round-robin arbiter sharing one registered-ack memory port between three
// Wishbone masters, one single-beat transaction at a time, with a bounded
// wait for the slave before an error is returned to the owner.
//
// state | meaning
// IDLE  | no owner; arbitrate among pending requests
// ISSUE | strobe the memory for one cycle on behalf of the owner
// WAIT  | hold cyc, wait for ack/err/timeout or an owner abort
module wb_mem_arbiter
    import wb_arb_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic             port0_wb_clk_i,
    input  logic             port0_wb_rst_i,
    input  logic [2:0]       m_cyc_i,
    input  logic [2:0]       m_stb_i,
    input  logic [2:0]       m_we_i,
    input  logic [2:0][31:0] m_adr_i,
    input  logic [2:0][31:0] m_dat_i,
    input  logic [2:0][3:0]  m_sel_i,
    output logic [2:0]       m_ack_o,
    output logic [2:0]       m_err_o,
    output logic [2:0]       m_stall_o,
    output logic [31:0]      m_dat_o,
    output logic             s_cyc_o,
    output logic             s_stb_o,
    output logic             s_we_o,
    output logic [31:0]      s_adr_o,
    output logic [31:0]      s_dat_o,
    output logic [3:0]       s_sel_o,
    input  logic             s_ack_i,
    input  logic             s_err_i,
    input  logic [31:0]      s_dat_i,
    output logic [2:0]       grant_o
);

    localparam int CW = cnt_width(TIMEOUT);

    arb_state_t    r_state;
    arb_state_t    w_next;
    logic [2:0]    r_grant;
    logic [1:0]    r_last;
    logic [CW-1:0] r_cnt;

    logic [2:0]    w_req;
    logic [2:0]    w_pick;
    logic          w_pick_valid;
    logic          w_own_cyc;
    logic          w_done;
    logic [1:0]    w_gidx;

    assign w_req     = m_cyc_i & m_stb_i;
    assign w_own_cyc = |(r_grant & m_cyc_i);
    assign w_gidx    = r_grant[2] ? 2'd2 : (r_grant[1] ? 2'd1 : 2'd0);
    assign m_dat_o   = s_dat_i;
    assign grant_o   = r_grant;

    rr_pick u_rr_pick (
        .i_req   (w_req),
        .i_last  (r_last),
        .o_grant (w_pick),
        .o_valid (w_pick_valid)
    );

    // State register.
    always_ff @(posedge port0_wb_clk_i or posedge port0_wb_rst_i) begin
        if (port0_wb_rst_i) r_state <= ST_IDLE;
        else                r_state <= w_next;
    end

    // Next state and handshake outputs; an owner abort beats any slave reply.
    always_comb begin
        w_next  = r_state;
        w_done  = 1'b0;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        m_ack_o = '0;
        m_err_o = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) w_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (!w_own_cyc) begin
                    w_done = 1'b1;
                end else begin
                    s_cyc_o = 1'b1;
                    s_stb_o = 1'b1;
                    w_next  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!w_own_cyc) begin
                    w_done = 1'b1;
                end else begin
                    s_cyc_o = 1'b1;
                    if (s_err_i) begin
                        m_err_o = r_grant;
                        w_done  = 1'b1;
                    end else if (s_ack_i) begin
                        m_ack_o = r_grant;
                        w_done  = 1'b1;
                    end else if (r_cnt == CW'(TIMEOUT)) begin
                        m_err_o = r_grant;
                        w_done  = 1'b1;
                    end
                end
            end
            default: w_next = ST_IDLE;
        endcase
        if (w_done) w_next = ST_IDLE;
    end

    // Owner, last-served and WAIT-cycle counter registers.
    always_ff @(posedge port0_wb_clk_i or posedge port0_wb_rst_i) begin
        if (port0_wb_rst_i) begin
            r_grant <= '0;
            r_last  <= 2'd2;
            r_cnt   <= '0;
        end else begin
            if (r_state == ST_IDLE && w_pick_valid) begin
                r_grant <= w_pick;
            end else if (w_done) begin
                r_grant <= '0;
                r_last  <= w_gidx;
            end
            if (r_state == ST_ISSUE || w_done) r_cnt <= '0;
            else if (r_state == ST_WAIT)       r_cnt <= r_cnt + 1'b1;
        end
    end

    // Forward the owner's request fields; zero when nobody owns the bus.
    always_comb begin
        s_we_o    = 1'b0;
        s_adr_o   = '0;
        s_dat_o   = '0;
        s_sel_o   = '0;
        m_stall_o = 3'b111;
        for (int i = 0; i < NUM_M; i++) begin
            if (r_grant[i]) begin
                s_we_o  = m_we_i[i];
                s_adr_o = m_adr_i[i];
                s_dat_o = m_dat_i[i];
                s_sel_o = m_sel_i[i];
                if (r_state == ST_ISSUE) m_stall_o[i] = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Directed bench for wb_mem_arbiter with a registered-ack scratch memory.
module tb_wb_mem_arbiter;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [2:0]       m_cyc = '0, m_stb = '0, m_we = '0;
    logic [2:0][31:0] m_adr = '0, m_dat = '0;
    logic [2:0][3:0]  m_sel = '0;
    logic [2:0]       m_ack, m_err, m_stall, grant;
    logic [31:0]      m_rdat;
    logic             s_cyc, s_stb, s_we, s_ack, s_err;
    logic [31:0]      s_adr, s_wdat, s_rdat;
    logic [3:0]       s_sel;

    logic [31:0] mem [0:63];
    logic        r_mack;
    logic [31:0] r_mdat;
    logic        force_noack = 1'b0, stray_ack = 1'b0, stray_err = 1'b0;

    int total = 0, passed = 0;

    always #5 clk = ~clk;

    wb_mem_arbiter #(.TIMEOUT(15)) dut (
        .port0_wb_clk_i(clk), .port0_wb_rst_i(rst),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
        .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel),
        .m_ack_o(m_ack), .m_err_o(m_err), .m_stall_o(m_stall), .m_dat_o(m_rdat),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we),
        .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_sel_o(s_sel),
        .s_ack_i(s_ack), .s_err_i(s_err), .s_dat_i(s_rdat), .grant_o(grant)
    );

    assign s_ack  = r_mack | stray_ack;
    assign s_err  = stray_err;
    assign s_rdat = r_mdat;

    // Scratch memory: registered ack and read data one cycle after the strobe.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h1000_0000 + 32'(i);
            mem[2]  <= 32'hAABB_CCDD;
            mem[16] <= 32'hDEAD_BEEF;
            r_mack  <= 1'b0;
            r_mdat  <= '0;
        end else begin
            r_mack <= s_cyc & s_stb & ~force_noack;
            r_mdat <= '0;
            if (s_cyc && s_stb) begin
                if (s_we) begin
                    for (int b = 0; b < 4; b++)
                        if (s_sel[b]) mem[s_adr[7:2]][8*b +: 8] <= s_wdat[8*b +: 8];
                end else begin
                    r_mdat <= mem[s_adr[7:2]];
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic we, input logic [31:0] adr,
                           input logic [31:0] dat, input logic [3:0] sel);
        m_cyc[i] = 1'b1; m_stb[i] = 1'b1; m_we[i] = we;
        m_adr[i] = adr;  m_dat[i] = dat;  m_sel[i] = sel;
    endtask

    task automatic clr_req(input int i);
        m_cyc[i] = 1'b0; m_stb[i] = 1'b0; m_we[i] = 1'b0;
    endtask

    task automatic test_reset();
        tick(); tick();
        total++; if ({grant, m_stall} !== 6'b000_111) $display("FAIL reset_grant_stall got %b want 000111", {grant, m_stall}); else passed++;
        total++; if ({s_cyc, s_stb, s_we, s_sel, m_ack, m_err} !== 13'd0) $display("FAIL reset_outputs got %b want 0", {s_cyc, s_stb, s_we, s_sel, m_ack, m_err}); else passed++;
        total++; if (s_adr !== 32'd0) $display("FAIL reset_adr got %h want 0", s_adr); else passed++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_read();
        set_req(1, 1'b0, 32'h40, 32'h0, 4'hF);
        total++; if (s_stb !== 1'b0) $display("FAIL read_idle_stb got %b want 0", s_stb); else passed++;
        tick();
        total++; if ({s_cyc, s_stb, grant} !== 5'b11_010) $display("FAIL read_issue got %b want 11010", {s_cyc, s_stb, grant}); else passed++;
        total++; if (s_adr !== 32'h40) $display("FAIL read_adr got %h want 40", s_adr); else passed++;
        total++; if (m_stall !== 3'b101) $display("FAIL read_stall got %b want 101", m_stall); else passed++;
        tick();
        total++; if ({m_ack, s_stb, s_cyc} !== 5'b010_0_1) $display("FAIL read_ack got %b want 01001", {m_ack, s_stb, s_cyc}); else passed++;
        total++; if (m_rdat !== 32'hDEAD_BEEF) $display("FAIL read_data got %h want deadbeef", m_rdat); else passed++;
        tick();
        clr_req(1);
        total++; if (grant !== 3'b000) $display("FAIL read_idle_grant got %b want 000", grant); else passed++;
        tick();
    endtask

    task automatic test_byte_write();
        set_req(0, 1'b1, 32'h8, 32'h1122_3344, 4'b0100);
        tick();
        total++; if ({s_we, s_sel, s_wdat} !== {1'b1, 4'b0100, 32'h1122_3344}) $display("FAIL wr_fields got %b %b %h", s_we, s_sel, s_wdat); else passed++;
        tick();
        total++; if (m_ack !== 3'b001) $display("FAIL wr_ack got %b want 001", m_ack); else passed++;
        tick();
        set_req(0, 1'b0, 32'h8, 32'h0, 4'hF);
        tick(); tick();
        total++; if (m_ack !== 3'b001) $display("FAIL wr_rd_ack got %b want 001", m_ack); else passed++;
        total++; if (m_rdat !== 32'hAA22_CCDD) $display("FAIL wr_rd_data got %h want aa22ccdd", m_rdat); else passed++;
        tick();
        clr_req(0);
        tick();
    endtask

    task automatic test_timeout();
        force_noack = 1'b1;
        set_req(2, 1'b0, 32'h40, 32'h0, 4'hF);
        for (int k = 1; k <= 17; k++) begin
            tick();
            if (k == 16) begin
                total++; if (m_err !== 3'b000) $display("FAIL to_early got %b want 000", m_err); else passed++;
            end
            if (k == 17) begin
                total++; if ({m_err, m_ack} !== 6'b100_000) $display("FAIL to_err got %b want 100000", {m_err, m_ack}); else passed++;
            end
        end
        tick();
        total++; if ({grant, m_err, s_cyc} !== 7'd0) $display("FAIL to_idle got %b want 0", {grant, m_err, s_cyc}); else passed++;
        clr_req(2);
        force_noack = 1'b0;
        tick();
        set_req(2, 1'b0, 32'h40, 32'h0, 4'hF);
        tick(); tick();
        total++; if ({m_ack, m_err} !== 6'b100_000) $display("FAIL to_next_ack got %b want 100000", {m_ack, m_err}); else passed++;
        total++; if (m_rdat !== 32'hDEAD_BEEF) $display("FAIL to_next_data got %h want deadbeef", m_rdat); else passed++;
        tick();
        clr_req(2);
        tick();
    endtask

    task automatic test_contention();
        logic [2:0]  exp_ack;
        logic [31:0] exp_dat;
        set_req(0, 1'b0, 32'h00, 32'h0, 4'hF);
        set_req(1, 1'b0, 32'h04, 32'h0, 4'hF);
        set_req(2, 1'b0, 32'h0C, 32'h0, 4'hF);
        for (int k = 1; k <= 12; k++) begin
            tick();
            case (k)
                2:       begin exp_ack = 3'b001; exp_dat = 32'h1000_0000; end
                5:       begin exp_ack = 3'b010; exp_dat = 32'h1000_0001; end
                8:       begin exp_ack = 3'b100; exp_dat = 32'h1000_0003; end
                11:      begin exp_ack = 3'b001; exp_dat = 32'h1000_0000; end
                default: begin exp_ack = 3'b000; exp_dat = 32'h0; end
            endcase
            total++; if (m_ack !== exp_ack) $display("FAIL rr_ack_c%0d got %b want %b", k, m_ack, exp_ack); else passed++;
            if (exp_ack != 3'b000) begin
                total++; if (m_rdat !== exp_dat) $display("FAIL rr_data_c%0d got %h want %h", k, m_rdat, exp_dat); else passed++;
            end
        end
        clr_req(0); clr_req(1); clr_req(2);
        tick();
    endtask

    task automatic test_err_wins();
        set_req(1, 1'b0, 32'h40, 32'h0, 4'hF);
        tick(); tick();
        stray_err = 1'b1;
        #1;
        total++; if ({m_err, m_ack} !== 6'b010_000) $display("FAIL errwin got %b want 010000", {m_err, m_ack}); else passed++;
        tick();
        stray_err = 1'b0;
        clr_req(1);
        total++; if (grant !== 3'b000) $display("FAIL errwin_idle got %b want 000", grant); else passed++;
        tick();
    endtask

    task automatic test_abort();
        force_noack = 1'b1;
        set_req(0, 1'b0, 32'h40, 32'h0, 4'hF);
        tick(); tick();
        total++; if ({s_cyc, grant} !== 4'b1_001) $display("FAIL abort_wait got %b want 1001", {s_cyc, grant}); else passed++;
        clr_req(0);
        #1;
        total++; if ({s_cyc, s_stb, m_ack, m_err} !== 8'd0) $display("FAIL abort_drop got %b want 0", {s_cyc, s_stb, m_ack, m_err}); else passed++;
        tick();
        stray_ack = 1'b1;
        #1;
        total++; if ({m_ack, m_err, grant} !== 9'd0) $display("FAIL abort_stray got %b want 0", {m_ack, m_err, grant}); else passed++;
        tick();
        stray_ack = 1'b0;
        force_noack = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_wait();
        force_noack = 1'b1;
        set_req(1, 1'b0, 32'h40, 32'h0, 4'hF);
        tick(); tick();
        rst = 1'b1;
        #1;
        total++; if ({s_cyc, s_stb, grant, m_stall} !== 8'b0_0_000_111) $display("FAIL rstw_outputs got %b want 00000111", {s_cyc, s_stb, grant, m_stall}); else passed++;
        set_req(0, 1'b0, 32'h40, 32'h0, 4'hF);
        force_noack = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        total++; if ({grant, s_stb} !== 4'b001_1) $display("FAIL rstw_first_grant got %b want 0011", {grant, s_stb}); else passed++;
        tick();
        total++; if (m_ack !== 3'b001) $display("FAIL rstw_ack got %b want 001", m_ack); else passed++;
        tick();
        clr_req(0); clr_req(1);
        tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_byte_write();
        test_timeout();
        test_contention();
        test_err_wins();
        test_abort();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
